// File: rtl/aes_package.sv
// Shared types and constants for the AES round sequencer slice.
// Controller-side bundles, FSM encoding and key-length decode.
package aes_package;

   localparam int AES_NR_128 = 10;
   localparam int AES_NR_192 = 12;
   localparam int AES_NR_256 = 14;
   localparam int AES_BLK_W  = 128;
   localparam int AES_CNT_W  = 16;

   typedef enum logic [1:0] {
      KEY128   = 2'd0,
      KEY192   = 2'd1,
      KEY256   = 2'd2,
      KEY_RSVD = 2'd3
   } aes_key_len_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      ROUND  = 3'd2,
      OUTPUT = 3'd3,
      DONE   = 3'd4
   } aes_seq_state_e;

   typedef struct packed {
      logic                 start;
      logic [AES_CNT_W-1:0] nb_blocks;
      aes_key_len_e         key_len;
      logic                 decrypt;
   } ctrl_seq_t;

   typedef struct packed {
      logic busy;
      logic done;
      logic cfg_err;
   } flags_seq_t;

   // Reserved key length runs the longest schedule
   function automatic logic [3:0] aes_nr(input aes_key_len_e kl);
      logic [3:0] nr;
      unique case (kl)
         KEY128:  nr = 4'(AES_NR_128);
         KEY192:  nr = 4'(AES_NR_192);
         default: nr = 4'(AES_NR_256);
      endcase
      return nr;
   endfunction

endpackage

// File: rtl/aes_perf_cnt.sv
// Saturating 32-bit-style enable counter for busy-cycle profiling.
// Zeroed on job start, cleared by reset or soft clear.
module aes_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         zero_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   // count enabled cycles, stick at all-ones
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         cnt_q <= '0;
      end else if (zero_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_round_seq.sv
// Block sequencer: load, Nr+1 round steps, store, per job.
// Busy-cycle counter built only with AES_ROUND_SEQ_PERF_CNT_EN.
module aes_round_seq
   import aes_package::*;
#(
   parameter int CNT_W     = 16,
   parameter int KEY_IDX_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [CNT_W-1:0]     nb_blocks_i,
   input  logic [1:0]           key_len_i,
   input  logic                 decrypt_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [AES_BLK_W-1:0] in_data_i,
   output logic [AES_BLK_W-1:0] rnd_state_o,
   output logic [KEY_IDX_W-1:0] rnd_idx_o,
   output logic                 rnd_first_o,
   output logic                 rnd_last_o,
   output logic                 rnd_decrypt_o,
   input  logic [AES_BLK_W-1:0] rnd_result_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [AES_BLK_W-1:0] out_data_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 cfg_err_o,
   output logic [31:0]          perf_cnt_o
);

   aes_seq_state_e       state_q, state_d;
   logic [AES_BLK_W-1:0] blk_q, blk_d;
   logic [CNT_W-1:0]     nb_q, nb_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
   logic [KEY_IDX_W-1:0] nr_q, nr_d;
   logic                 dec_q, dec_d;
   logic                 err_q, err_d;
   flags_seq_t           flags;

   // registers; soft clear behaves exactly like reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         state_q <= IDLE;
         blk_q   <= '0;
         nb_q    <= '0;
         cnt_q   <= '0;
         rnd_q   <= '0;
         nr_q    <= '0;
         dec_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         nb_q    <= nb_d;
         cnt_q   <= cnt_d;
         rnd_q   <= rnd_d;
         nr_q    <= nr_d;
         dec_q   <= dec_d;
         err_q   <= err_d;
      end
   end

   // next-state and handshake/round qualifier decode
   always_comb begin
      state_d       = state_q;
      blk_d         = blk_q;
      nb_d          = nb_q;
      cnt_d         = cnt_q;
      rnd_d         = rnd_q;
      nr_d          = nr_q;
      dec_d         = dec_q;
      err_d         = err_q;
      in_ready_o    = 1'b0;
      out_valid_o   = 1'b0;
      rnd_idx_o     = '0;
      rnd_first_o   = 1'b0;
      rnd_last_o    = 1'b0;
      rnd_decrypt_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               nb_d  = nb_blocks_i;
               dec_d = decrypt_i;
               nr_d  = KEY_IDX_W'(aes_nr(aes_key_len_e'(key_len_i)));
               err_d = (key_len_i == 2'(KEY_RSVD));
               cnt_d = '0;
               state_d = (nb_blocks_i == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               blk_d   = in_data_i;
               rnd_d   = '0;
               state_d = ROUND;
            end
         end
         ROUND: begin
            rnd_idx_o     = dec_q ? (nr_q - rnd_q) : rnd_q;
            rnd_first_o   = (rnd_q == '0);
            rnd_last_o    = (rnd_q == nr_q);
            rnd_decrypt_o = dec_q;
            blk_d         = rnd_result_i;
            rnd_d         = rnd_q + KEY_IDX_W'(1);
            if (rnd_q == nr_q) begin
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = (cnt_d == nb_q) ? DONE : LOAD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign flags.busy    = (state_q != IDLE);
   assign flags.done    = (state_q == DONE);
   assign flags.cfg_err = err_q;

   assign busy_o      = flags.busy;
   assign done_o      = flags.done;
   assign cfg_err_o   = flags.cfg_err;
   assign rnd_state_o = blk_q;
   assign out_data_o  = blk_q;

`ifdef AES_ROUND_SEQ_PERF_CNT_EN
   logic start_acc;

   assign start_acc = start_i && (state_q == IDLE);

   aes_perf_cnt #(
      .W(32)
   ) u_perf_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear_i(clear_i),
      .zero_i (start_acc),
      .en_i   (flags.busy),
      .cnt_o  (perf_cnt_o)
   );
`else
   assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq with an attached AES round model.
// Golden results queued at load handshake, compared at store.
module tb_aes_round_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear;
   logic         start;
   logic [15:0]  nb;
   logic [1:0]   kl;
   logic         dec;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] rnd_state;
   logic [3:0]   rnd_idx;
   logic         rnd_first;
   logic         rnd_last;
   logic         rnd_dec;
   logic [127:0] rnd_result;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   logic         done;
   logic         cfg_err;
   logic [31:0]  perf;

   int           n_tests = 0;
   int           n_fail = 0;
   int           exp_nr = 10;
   bit           exp_dec = 1'b0;
   logic [127:0] sb[$];
   logic [127:0] last_out;
   logic         prev_ov = 1'b0;
   logic         prev_or = 1'b0;
   logic [127:0] prev_data = '0;
   logic [7:0]   sbox[256];
   logic [127:0] rk[15];

   always #5 clk = ~clk;

   aes_round_seq dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear),
      .start_i      (start),
      .nb_blocks_i  (nb),
      .key_len_i    (kl),
      .decrypt_i    (dec),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .rnd_state_o  (rnd_state),
      .rnd_idx_o    (rnd_idx),
      .rnd_first_o  (rnd_first),
      .rnd_last_o   (rnd_last),
      .rnd_decrypt_o(rnd_dec),
      .rnd_result_i (rnd_result),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_data_o   (out_data),
      .busy_o       (busy),
      .done_o       (done),
      .cfg_err_o    (cfg_err),
      .perf_cnt_o   (perf)
   );

   task automatic chk(input string tag, input logic [127:0] act,
                      input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in,
                                       input logic [7:0] b_in);
      logic [7:0] a = a_in;
      logic [7:0] b = b_in;
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] aes_rnd(input logic [127:0] s,
                                            input logic [3:0] idx,
                                            input bit first,
                                            input bit last);
      logic [7:0]   b[16];
      logic [7:0]   t[16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      if (first) return s ^ rk[idx];
      for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[c*4+r] = b[((c+r)%4)*4+r];
      for (int c = 0; c < 4; c++) begin
         a0 = t[c*4];
         a1 = t[c*4+1];
         a2 = t[c*4+2];
         a3 = t[c*4+3];
         if (last) begin
            b[c*4] = a0; b[c*4+1] = a1; b[c*4+2] = a2; b[c*4+3] = a3;
         end else begin
            b[c*4]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
            b[c*4+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
            b[c*4+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
            b[c*4+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
      return o ^ rk[idx];
   endfunction

   function automatic logic [127:0] golden(input logic [127:0] pt,
                                           input int nr, input bit d);
      logic [127:0] s = pt;
      for (int k = 0; k <= nr; k++)
         s = aes_rnd(s, 4'(d ? nr - k : k), k == 0, k == nr);
      return s;
   endfunction

   task automatic init_model();
      logic [31:0]  w[44];
      logic [31:0]  tmp;
      logic [7:0]   x, y, rcon;
      logic [127:0] key = 128'h000102030405060708090a0b0c0d0e0f;
      for (int v = 0; v < 256; v++) begin
         x = 8'h01;
         if (v == 0) x = 8'h00;
         else for (int i = 0; i < 254; i++) x = gmul(x, 8'(v));
         y = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]}
               ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
         sbox[v] = y;
      end
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]],
                   sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 2);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++)
         rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = 11; r < 15; r++)
         rk[r] = {rk[r-1][119:0], rk[r-1][127:120]} ^ {16{8'(r * 17)}};
   endtask

   assign rnd_result = aes_rnd(rnd_state, rnd_idx, rnd_first, rnd_last);

   // scoreboard: push on load handshake, pop on store handshake
   always @(negedge clk) begin
      if (in_valid && in_ready)
         sb.push_back(golden(in_data, exp_nr, exp_dec));
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_empty", 1, 0);
         else chk("out_data", out_data, sb.pop_front());
      end
      if (out_valid && prev_ov && !prev_or)
         chk("stall_hold", out_data, prev_data);
      prev_ov   <= out_valid;
      prev_or   <= out_ready;
      prev_data <= out_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n, input int k, input bit d);
      start = 1'b1;
      nb    = 16'(n);
      kl    = 2'(k);
      dec   = d;
      exp_nr  = (k == 0) ? 10 : (k == 1) ? 12 : 14;
      exp_dec = d;
      tick();
      start = 1'b0;
   endtask

   task automatic run_block(input logic [127:0] data, input int gap,
                            input int stall);
      int n = 0;
      repeat (gap) tick();
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = data;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= exp_nr; k++) begin
         chk("rnd_q", {out_valid, rnd_idx, rnd_first, rnd_last, rnd_dec},
             {1'b0, 4'(exp_dec ? exp_nr - k : k), k == 0, k == exp_nr,
              exp_dec});
         tick();
      end
      chk("latency", out_valid, 1);
      last_out = out_data;
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_job(input int n, input int k, input bit d,
                          input int gap, input int stall_blk,
                          input int stall_n);
      do_start(n, k, d);
      for (int b = 0; b < n; b++)
         run_block({$urandom, $urandom, $urandom, $urandom}, gap,
                   (b == stall_blk) ? stall_n : 0);
      chk("done_pulse", {done, busy}, 2'b11);
      tick();
      chk("done_end", {done, busy}, 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; start = 1'b0; nb = '0; kl = '0;
      dec = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      init_model();
      repeat (3) tick();
      chk("rst_ctl", {busy, done, cfg_err, in_ready, out_valid,
                      rnd_idx, rnd_first, rnd_last, rnd_dec}, '0);
      chk("rst_data", rnd_state | out_data, '0);
      chk("rst_perf", perf, 0);
      rst_n = 1'b1;
      tick();

      do_start(1, 0, 1'b0);
      run_block(128'h00112233445566778899aabbccddeeff, 0, 0);
      chk("fips197", last_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("done_fips", {done, busy}, 2'b11);
      tick();
      chk("idle_fips", {done, busy}, 2'b00);

      run_job(3, 2, 1'b0, 2, 1, 5);

      do_start(0, 0, 1'b0);
      chk("nb0_done", {done, busy, in_ready}, 3'b110);
      tick();
      chk("nb0_idle", {done, busy, in_ready}, 3'b000);

      do_start(1, 3, 1'b0);
      chk("cfg_err_set", cfg_err, 1);
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
      tick();
      chk("cfg_err_hold", cfg_err, 1);

      run_job(1, 1, 1'b1, 0, -1, 0);
      chk("cfg_err_clr", cfg_err, 0);

      do_start(4, 0, 1'b0);
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 0);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      in_valid = 1'b0;
      start = 1'b1;
      nb    = 16'd1;
      tick();
      start = 1'b0;
      chk("start_ignored", {busy, rnd_idx}, {1'b1, 4'd1});
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_ctl", {busy, done, cfg_err, in_ready, out_valid,
                      rnd_idx, rnd_first, rnd_last, rnd_dec}, '0);
      chk("clr_data", rnd_state | out_data, '0);
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("clr_no_done", {done, busy}, 2'b00);
      end

      run_job(2, 0, 1'b0, 0, -1, 0);
`ifdef AES_ROUND_SEQ_PERF_CNT_EN
      chk("perf", perf, 27);
      tick();
      chk("perf_hold", perf, 27);
`else
      chk("perf", perf, 0);
      tick();
      chk("perf_hold", perf, 0);
`endif
      chk("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
